// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, runs the req/ack handshake with instruction memory
// and hands instructions to decode through an output register backed by a one-entry skid.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_result
);

  typedef enum logic [1:0] {StBoot, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        flush;
  logic        complete;
  logic        deliver;
  logic        consume;
  logic [31:0] redir_pc;

  assign flush    = exc_valid | redirect_valid;
  assign complete = req_q & imem_ack;
  // A completion is only handed on if it was not orphaned by an earlier or concurrent redirect.
  assign deliver  = complete & ~drop_q & ~flush;
  assign consume  = out_valid_q & ~stall;
  assign redir_pc = exc_valid ? EXC_VECTOR : {redirect_target[31:2], 2'b00};

  // Next-state logic for the fetch FSM, PC and the memory request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    case (state_q)
      StBoot: state_d = StIssue;
      StIssue: begin
        // Hold off while the skid is occupied so at most two words are ever buffered.
        if (!flush && !skid_valid_q) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (complete) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = StIssue;
          if (!drop_q && !flush) pc_d = pc_q + 32'd4;
        end else if (flush) begin
          // The bus forbids withdrawing the request; remember to discard its response.
          drop_d = 1'b1;
        end
      end
      default: state_d = StBoot;
    endcase
    if (flush) pc_d = redir_pc;
  end

  // Next-state logic for the output register and skid buffer.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = deliver;
        if (deliver) begin
          skid_instr_d = imem_data;
          skid_pc_d    = addr_q;
        end
      end else if (deliver) begin
        out_instr_d = imem_data;
        out_pc_d    = addr_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (deliver) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_data;
        out_pc_d    = addr_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_data;
        skid_pc_d    = addr_q;
      end
    end
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VECTOR;
      req_q        <= 1'b0;
      addr_q       <= '0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = out_valid_q;
  assign instr       = out_instr_q;
  assign instr_pc    = out_pc_q;
  assign pc_result   = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer, checked every cycle against a queue-based model.
module tb_fetch_sequencer;

  localparam logic [31:0] ResetVec = 32'h0000_0000;
  localparam logic [31:0] ExcVec   = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        exc_valid = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_result;

  fetch_sequencer #(
    .RESET_VECTOR(ResetVec),
    .EXC_VECTOR  (ExcVec)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .exc_valid      (exc_valid),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_result      (pc_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch PC, one outstanding request, and a FIFO of words owed to decode.
  bit          m_booted;
  bit          m_busy;
  bit          m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [63:0] m_q[$];

  int stall_pct, redir_pct, exc_pct, ack_pct;
  bit          f_redir, f_exc;
  logic [31:0] f_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
  endfunction

  task automatic model_reset();
    m_booted  = 1'b0;
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_pc      = ResetVec;
    m_addr    = '0;
    m_q.delete();
  endtask

  task automatic model_step(input bit st, input bit rd, input bit ex, input bit ak,
                            input logic [31:0] tgt);
    bit flush;
    bit full;
    bit done;
    flush = rd | ex;
    full  = (m_q.size() == 2);
    done  = m_busy && ak;
    if (flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (done && !m_discard) m_q.push_back({mem_word(m_addr), m_addr});
    end
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_busy) begin
      if (done) begin
        m_busy = 1'b0;
        if (!m_discard && !flush) m_pc = m_pc + 32'd4;
        m_discard = 1'b0;
      end else if (flush) begin
        m_discard = 1'b1;
      end
    end else if (!flush && !full) begin
      m_busy = 1'b1;
      m_addr = m_pc;
    end
    if (ex) m_pc = ExcVec;
    else if (rd) m_pc = {tgt[31:2], 2'b00};
  endtask

  task automatic compare_outputs();
    check_eq("imem_req", 32'(imem_req), 32'(m_busy));
    check_eq("imem_addr", imem_addr, m_addr);
    check_eq("pc_result", pc_result, m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq("instr", instr, m_q[0][63:32]);
      check_eq("instr_pc", instr_pc, m_q[0][31:0]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
    check_eq({tag, "_addr"}, imem_addr, 32'd0);
    check_eq({tag, "_pc"}, pc_result, ResetVec);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_instr"}, instr, 32'd0);
    check_eq({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  // One clock: check current outputs, drive the next inputs, advance the model.
  task automatic cycle();
    compare_outputs();
    stall          = ($urandom_range(0, 99) < stall_pct);
    redirect_valid = f_redir || ($urandom_range(0, 99) < redir_pct);
    exc_valid      = f_exc || ($urandom_range(0, 99) < exc_pct);
    if (f_redir) redirect_target = f_tgt;
    else if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFF0 | $urandom_range(0, 15);
    else redirect_target = $urandom;
    imem_ack  = m_busy && ($urandom_range(0, 99) < ack_pct);
    imem_data = m_busy ? mem_word(m_addr) : $urandom;
    f_redir   = 1'b0;
    f_exc     = 1'b0;
    model_step(stall, redirect_valid, exc_valid, imem_ack, redirect_target);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_for_req();
    for (int i = 0; i < 20 && !imem_req; i++) cycle();
    check_eq("reach_wait", 32'(imem_req), 32'd1);
  endtask

  task automatic set_knobs(input int s, input int r, input int e, input int a);
    stall_pct = s;
    redir_pct = r;
    exc_pct   = e;
    ack_pct   = a;
  endtask

  initial begin
    f_redir = 1'b0;
    f_exc   = 1'b0;
    f_tgt   = '0;
    set_knobs(0, 0, 0, 100);
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate ack, sequential fetch.
    run(10);

    // Decode stalled: output holds, skid fills, no further requests.
    set_knobs(100, 0, 0, 100);
    run(6);
    set_knobs(0, 0, 0, 100);
    run(4);

    // Slow memory.
    set_knobs(0, 0, 0, 30);
    run(12);

    // Redirect during a wait; the response must be dropped.
    set_knobs(0, 0, 0, 0);
    wait_for_req();
    f_redir = 1'b1;
    f_tgt   = 32'h0000_0103;
    run(3);
    set_knobs(0, 0, 0, 100);
    run(6);

    // Exception and redirect together: exception wins.
    f_redir = 1'b1;
    f_exc   = 1'b1;
    f_tgt   = 32'h0000_4000;
    run(6);

    // PC wraps past the top of the address space.
    f_redir = 1'b1;
    f_tgt   = 32'hFFFF_FFF8;
    run(8);

    // Asynchronous reset in the middle of a wait.
    set_knobs(0, 0, 0, 0);
    wait_for_req();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exc_valid      = 1'b0;
    imem_ack       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_knobs(0, 0, 0, 100);
    run(8);

    // Random mix.
    for (int blk = 0; blk < 40; blk++) begin
      set_knobs($urandom_range(0, 60), $urandom_range(0, 12), $urandom_range(0, 5),
                $urandom_range(20, 100));
      run(100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter register and sequences instruction fetches from an instruction memory that has variable latency and a req/ack handshake.
- Selects the next PC from three sources: sequential (+4), a branch/jump redirect, or the exception vector.
- Presents fetched instructions to decode through a valid/stall interface, with a one-entry skid buffer.
- Sits between the instruction memory and the IF/ID stage register, and replaces the free-running PC update in the fetch unit.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- EXC_VECTOR, 32'h00000080, PC value loaded on an exception.

Ports:
- Clk, in, 1: system clock; all state updates on the rising edge.
- Reset, in, 1: asynchronous, active-low reset. Reset=0 clears immediately.
- Stall, in, 1: decode cannot accept the instruction this cycle.
- RedirectValid, in, 1: branch/jump taken this cycle.
- RedirectTarget, in, 32: redirect destination.
- ExcValid, in, 1: exception taken this cycle.
- ImemReq, out, 1: fetch request.
- ImemAddr, out, 32: fetch address.
- ImemAck, in, 1: single-cycle response strobe.
- ImemData, in, 32: instruction word, valid when ImemAck=1.
- InstrValid, out, 1: Instr and InstrPC are valid.
- Instr, out, 32: instruction to decode.
- InstrPC, out, 32: address of Instr.
- PCResult, out, 32: current fetch PC.

Behaviour:
- Reset (Reset=0): PCResult=RESET_VECTOR, ImemReq=0, ImemAddr=0, InstrValid=0, Instr=0, InstrPC=0, skid buffer empty, drop flag=0, state=BOOT.
- BOOT: after the first rising edge with Reset=1, go to ISSUE; no request is made in BOOT.
- ISSUE:
  - If the skid buffer is full, stay in ISSUE with ImemReq=0.
  - Otherwise drive ImemReq=1 and ImemAddr=PCResult, then go to WAIT.
  - If ImemAck arrives in the same cycle, complete as described under "Completion".
- WAIT: ImemReq stays 1 and ImemAddr stays stable until ImemAck=1. This is a bus rule: a request is never withdrawn before its ack, including across redirects.
- Completion (ImemReq & ImemAck):
  - If the drop flag is 0, the response is delivered and PCResult advances by 4 (modulo 2^32; 32'hFFFFFFFC wraps to 0).
  - Delivery goes to the output register if it is empty or being consumed this cycle (InstrValid & ~Stall). Otherwise it goes to the skid buffer.
  - InstrPC takes the completed ImemAddr.
  - Next state is ISSUE. Sequential back-to-back fetch issues one request every 2 cycles when ack is immediate.
- Consumption: the output register is consumed when InstrValid=1 and Stall=0. On the same edge it loads the skid buffer contents if the buffer is full; otherwise it clears InstrValid unless a new completion is loading it.
- Stall=1: Instr, InstrPC and InstrValid hold. Stall never blocks a redirect or an exception.
- Redirect/exception priority: ExcValid > RedirectValid > sequential.
- On ExcValid or RedirectValid:
  - PCResult loads EXC_VECTOR or {RedirectTarget[31:2],2'b00}.
  - The output register and skid buffer are flushed; InstrValid=0 on the next cycle.
  - A completion in the same cycle is discarded.
  - If in WAIT without ack, the drop flag is set and the state stays WAIT. When ack arrives, the data is discarded, the drop flag is cleared, and the state goes to ISSUE.
  - A redirect arriving during a dropped wait overwrites the PC; the newest redirect wins.
- No PC update occurs other than by completion, redirect or exception.
- Asynchronous reset mid-WAIT abandons the transaction. The instruction memory is reset by the same signal.

Test Plan:
- Reset, then ImemAck tied to ImemReq -> ImemAddr sequence 0x0, 0x4, 0x8; InstrPC matches each address; InstrValid first goes high 3 cycles after reset release.
- Ack delayed 3 cycles on the fetch at 0x4 -> ImemReq and ImemAddr=0x4 held for 4 cycles; PCResult stays 0x4 until ack, then becomes 0x8.
- Stall=1 for 5 cycles with Instr=0x8C010004 valid -> output held; a second completion lands in the skid buffer; no third request; after Stall drops, the skid word appears the next cycle.
- RedirectValid with target 0x00000103 during WAIT -> ack data discarded; next ImemAddr=0x00000100; InstrValid=0 the cycle after the redirect.
- ExcValid and RedirectValid asserted together -> PCResult=0x80.
- PCResult=0xFFFFFFFC completes -> PCResult=0x0.
- Reset pulsed low mid-WAIT -> all outputs return to reset values immediately, without a clock edge.
